// File: rtl/fact_mul_pkg.sv
// Shared constants for the fact_mul slave: register offsets, FSM states, STATUS bits.
// Build option FACT_MUL_RADIX4_EN selects the radix-4 datapath in fact_mul_core.
package fact_mul_pkg;

  localparam logic [7:0] OFF_OPA_LO  = 8'h0;
  localparam logic [7:0] OFF_OPA_HI  = 8'h1;
  localparam logic [7:0] OFF_OPB_LO  = 8'h2;
  localparam logic [7:0] OFF_OPB_HI  = 8'h3;
  localparam logic [7:0] OFF_RES0    = 8'h4;
  localparam logic [7:0] OFF_RES1    = 8'h5;
  localparam logic [7:0] OFF_RES2    = 8'h6;
  localparam logic [7:0] OFF_RES3    = 8'h7;
  localparam logic [7:0] OFF_OPSTART = 8'h8;
  localparam logic [7:0] OFF_STATUS  = 8'h9;
  localparam logic [7:0] OFF_INTR_EN = 8'hA;
  localparam logic [7:0] OFF_CLEAR   = 8'hB;
  localparam logic [7:0] NUM_REGS    = 8'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/fact_mul_core.sv
// Shift-add multiplier datapath and iteration counter.
// FACT_MUL_RADIX4_EN retires two multiplier bits per cycle instead of one.
module fact_mul_core
  import fact_mul_pkg::*;
#(
  parameter int OP_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] product,
  output logic              busy,
  output logic              done_pulse
);

`ifdef FACT_MUL_RADIX4_EN
  localparam int ITERS = OP_W / 2;
`else
  localparam int ITERS = OP_W;
`endif
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [2*OP_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;

`ifdef FACT_MUL_RADIX4_EN
  logic [OP_W+1:0]   a3_q, a3_d;
  logic [OP_W+1:0]   addend;
  // Upper bit of the 67-bit sum is provably zero, so 66 bits are kept.
  logic [OP_W+1:0]   sum;
`else
  logic [OP_W:0]     sum;
`endif

  assign done_pulse = run_q && (cnt_q == CNT_W'(ITERS));
  assign busy       = run_q;
  assign product    = prod_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
`ifdef FACT_MUL_RADIX4_EN
    a3_d     = a3_q;
    unique case (mplier_q[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, mcand_q};
      2'd2:    addend = {1'b0, mcand_q, 1'b0};
      default: addend = a3_q;
    endcase
    sum = {2'b00, prod_q[2*OP_W-1:OP_W]} + addend;
`else
    sum = {1'b0, prod_q[2*OP_W-1:OP_W]}
        + (mplier_q[0] ? {1'b0, mcand_q} : '0);
`endif
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
`ifdef FACT_MUL_RADIX4_EN
      a3_d     = {2'b00, a} + {1'b0, a, 1'b0};
`endif
    end else if (run_q) begin
      if (cnt_q == CNT_W'(ITERS)) begin
        run_d = 1'b0;
      end else begin
`ifdef FACT_MUL_RADIX4_EN
        prod_d   = {sum, prod_q[OP_W-1:2]};
        mplier_d = mplier_q >> 2;
`else
        prod_d   = {sum, prod_q[OP_W-1:1]};
        mplier_d = mplier_q >> 1;
`endif
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
`ifdef FACT_MUL_RADIX4_EN
      a3_q     <= '0;
`endif
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
`ifdef FACT_MUL_RADIX4_EN
      a3_q     <= a3_d;
`endif
    end
  end

endmodule

// File: rtl/fact_mul_slave.sv
// Bus-mapped 64x64 multiplier slave: register file, decode, job FSM, interrupt.
// Define FACT_MUL_RADIX4_EN for the faster radix-4 core.
module fact_mul_slave
  import fact_mul_pkg::*;
#(
  parameter logic [7:0] BASE = 8'h20,
  parameter int         OP_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        m_interrupt
);

  logic [OP_W-1:0]   opa_q, opa_d;
  logic [OP_W-1:0]   opb_q, opb_d;
  logic              ie_q, ie_d;
  logic              irq_q, irq_d;
  state_e            state_q, state_d;

  logic [7:0]        off;
  logic              hit, wr, rd;
  logic              start, clear;
  logic [2*OP_W-1:0] product;
  logic              core_busy, done_pulse;
  logic [31:0]       status;

  assign off = S_address - BASE;
  assign hit = S_sel && (S_address >= BASE) && (off < NUM_REGS);
  assign wr  = hit && S_wr;
  assign rd  = hit && !S_wr;

  fact_mul_core #(.OP_W(OP_W)) u_core (
    .clk        (clk),
    .rst        (reset),
    .start      (start),
    .a          (opa_q),
    .b          (opb_q),
    .product    (product),
    .busy       (core_busy),
    .done_pulse (done_pulse)
  );

  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    ie_d  = ie_q;
    start = 1'b0;
    clear = 1'b0;
    if (wr) begin
      case (off)
        OFF_OPA_LO:  opa_d[31:0]      = S_din;
        OFF_OPA_HI:  opa_d[OP_W-1:32] = S_din[OP_W-33:0];
        OFF_OPB_LO:  opb_d[31:0]      = S_din;
        OFF_OPB_HI:  opb_d[OP_W-1:32] = S_din[OP_W-33:0];
        OFF_OPSTART: start = S_din[0] && !core_busy;
        OFF_INTR_EN: ie_d  = S_din[0];
        OFF_CLEAR:   clear = S_din[0] && (state_q == ST_DONE);
        default:     ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (done_pulse) state_d = ST_DONE;
      ST_DONE: begin
        if (start)      state_d = ST_BUSY;
        else if (clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Rises one cycle after done; drops on the same edge as CLEAR or INTR_EN=0.
    irq_d = ie_d && (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = core_busy;
    status[STAT_DONE] = (state_q == ST_DONE);
    S_dout = '0;
    if (rd) begin
      case (off)
        OFF_OPA_LO:  S_dout = opa_q[31:0];
        OFF_OPA_HI:  S_dout = opa_q[OP_W-1:32];
        OFF_OPB_LO:  S_dout = opb_q[31:0];
        OFF_OPB_HI:  S_dout = opb_q[OP_W-1:32];
        OFF_RES0:    S_dout = product[31:0];
        OFF_RES1:    S_dout = product[63:32];
        OFF_RES2:    S_dout = product[95:64];
        OFF_RES3:    S_dout = product[127:96];
        OFF_STATUS:  S_dout = status;
        OFF_INTR_EN: S_dout = {31'b0, ie_q};
        default:     S_dout = '0;
      endcase
    end
  end

  assign m_interrupt = irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_q   <= '0;
      opb_q   <= '0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fact_mul_slave.sv
// Randomized bench for fact_mul_slave against an arithmetic product/latency model.
// Build with FACT_MUL_RADIX4_EN to match a radix-4 DUT.
module tb_fact_mul_slave;

  localparam logic [7:0] BASE = 8'h20;
`ifdef FACT_MUL_RADIX4_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S_dout;
  logic        m_interrupt;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  fact_mul_slave dut (
    .clk         (clk),
    .reset       (reset),
    .S_sel       (S_sel),
    .S_wr        (S_wr),
    .S_address   (S_address),
    .S_din       (S_din),
    .S_dout      (S_dout),
    .m_interrupt (m_interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mul_ref(input logic [63:0] a,
                                           input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'b0, a};
    wb = {64'b0, b};
    return wa * wb;
  endfunction

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b1; S_address = BASE + off; S_din = d;
    @(posedge clk); #1;
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic bus_rd_abs(input logic [7:0] addr, output logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b0; S_address = addr;
    #1;
    d = S_dout;
    S_sel = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] off, output logic [31:0] d);
    bus_rd_abs(BASE + off, d);
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b);
    bus_wr(8'h0, a[31:0]);
    bus_wr(8'h1, a[63:32]);
    bus_wr(8'h2, b[31:0]);
    bus_wr(8'h3, b[63:32]);
  endtask

  task automatic start_job();
    bus_wr(8'h8, 32'h1);
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    bit bad = 0;
    bit tmo = 0;
    forever begin
      bus_rd(8'h9, s);
      if (s == 32'h2) break;
      if (s != 32'h1) bad = 1;
      if (cyc - t0 > 200) begin tmo = 1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_timeout"}, tmo, 0);
    check({tag, "_busy"}, bad, 0);
    check({tag, "_latency"}, cyc - t0, LAT);
  endtask

  task automatic rd_prod(output logic [127:0] p);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      bus_rd(8'h4 + 8'(i), w);
      p[32*i +: 32] = w;
    end
  endtask

  task automatic run_job(input string tag, input logic [63:0] a,
                         input logic [63:0] b, output logic [127:0] p);
    load(a, b);
    start_job();
    wait_done(tag);
    rd_prod(p);
    check({tag, "_prod"}, p, mul_ref(a, b));
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] w;
    for (int i = 0; i < 12; i++) begin
      bus_rd(8'(i), w);
      check($sformatf("%s_reg%0d", tag, i), w, 0);
    end
  endtask

  initial begin
    logic [127:0] p;
    logic [31:0]  w;
    logic [63:0]  acc, fref, ra, rb;

    reset = 1'b1; S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", m_interrupt, 0);
    check("rst_dout_idle", S_dout, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst");

    run_job("5x4", 64'd5, 64'd4, p);
    check("5x4_res0", p[31:0], 20);

    run_job("max", '1, '1, p);
    check("max_res3", p[127:96], 32'hFFFF_FFFF);
    check("max_res2", p[95:64], 32'hFFFF_FFFE);
    check("max_res0", p[31:0], 32'h1);

    load(64'd7, 64'd6);
    start_job();
    repeat (10) begin @(posedge clk); #1; end
    bus_wr(8'h0, 32'd9);
    bus_wr(8'h8, 32'h1);
    wait_done("midbusy");
    rd_prod(p);
    check("midbusy_prod", p, 42);
    bus_rd(8'h0, w);
    check("midbusy_opa", w, 9);

    bus_wr(8'hA, 32'h1);
    bus_rd(8'hA, w);
    check("ie_rd", w, 1);
    load(64'd3, 64'd3);
    start_job();
    wait_done("irq");
    check("irq_at_done", m_interrupt, 0);
    @(posedge clk); #1;
    check("irq_after_done", m_interrupt, 1);
    bus_wr(8'hB, 32'h1);
    check("irq_clear", m_interrupt, 0);
    bus_rd(8'h9, w);
    check("clear_status", w, 0);
    bus_rd(8'h4, w);
    check("clear_res0", w, 9);

    load({$urandom, $urandom}, {$urandom, $urandom});
    start_job();
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort_irq", m_interrupt, 0);
    check_all_zero("abort");
    reset = 1'b0;
    @(posedge clk); #1;
    run_job("2x3", 64'd2, 64'd3, p);

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 1) ra = ra >> $urandom_range(63, 1);
      if (i == 2) rb = 64'($urandom_range(3, 0));
      run_job($sformatf("rnd%0d", i), ra, rb, p);
    end

    bus_wr(8'hC, 32'hDEAD);
    bus_rd_abs(BASE + 8'hC, w);
    check("unmapped_2c", w, 0);
    bus_rd_abs(BASE - 8'h1, w);
    check("unmapped_1f", w, 0);
    bus_wr(8'h8, 32'h2);
    bus_rd(8'h9, w);
    check("start_bit0_0", w, 2);

    acc  = 64'd1;
    fref = 64'd1;
    for (int i = 1; i <= 20; i++) begin
      run_job($sformatf("fact%0d", i), acc, 64'(i), p);
      acc  = p[63:0];
      fref = fref * 64'(i);
    end
    check("fact20_model", acc, fref);
    check("fact20_const", acc, 64'h21C3_677C_82B4_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
